skid_buf_i8: RTL



---
 rtl/skid_buf_i8_pkg.sv | 6 +
 rtl/skid_buf_i8_en_reg.sv | 17 +
 rtl/skid_buf_i8.sv | 47 ++++
 3 files changed

// File: rtl/skid_buf_i8_pkg.sv
// skid_pkg: state encoding and default parameters shared by the skid buffer files
package skid_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_INIT = 3;
endpackage

// File: rtl/skid_buf_i8_en_reg.sv
// en_reg: register with synchronous reset to INIT and load enable
module en_reg
    import skid_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT = WIDTH'(DEF_INIT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock)
        if (reset) q <= INIT;
        else if (en) q <= d;
endmodule

// File: rtl/skid_buf_i8.sv
// skid_buf_i8: two-entry valid/ready skid buffer with registered in_ready and outputs
module skid_buf_i8
    import skid_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT = WIDTH'(DEF_INIT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [1:0] state;
    state_t st, nxt;
    logic in_fire, out_fire, load_main, load_skid, sel_skid;
    logic [WIDTH-1:0] skid, main_d;
    // the unused encoding 2'd3 behaves exactly like EMPTY
    assign st = (state == BUSY || state == FULL) ? state_t'(state) : EMPTY;
    always_ff @(posedge clock)
        if (reset) state <= EMPTY;
        else state <= nxt;
    always_comb begin
        nxt = (st == FULL) ? (out_fire ? BUSY : FULL) :
              (st == BUSY) ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : BUSY) :
              (in_fire ? BUSY : EMPTY);
    end
    always_comb begin
        in_ready  = (st != FULL) && !reset;
        out_valid = (st != EMPTY);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        load_skid = (st == BUSY) && in_fire && !out_fire;
        load_main = (in_fire && (st == EMPTY || out_fire)) || (st == FULL && out_fire);
        sel_skid  = (st == FULL);
    end
    assign main_d = sel_skid ? skid : in_data;
    en_reg #(.WIDTH(WIDTH), .INIT(INIT)) u_main (
        .clock(clock), .reset(reset), .en(load_main), .d(main_d), .q(out_data)
    );
    en_reg #(.WIDTH(WIDTH), .INIT(INIT)) u_skid (
        .clock(clock), .reset(reset), .en(load_skid), .d(in_data), .q(skid)
    );
endmodule
